// File: rtl/modem_link_ctrl_pkg.sv
// Shared types and default timing for the modem link supervisor.
package modem_link_ctrl_pkg;

  localparam int unsigned NOISE_MAG_WIDTH   = 8;
  localparam int unsigned LINK_LOCK_TIMEOUT = 800;
  localparam int unsigned LINK_LOCK_HOLD    = 16;
  localparam int unsigned LINK_UNLOCK_HOLD  = 32;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFlush   = 3'd1,
    StWarmup  = 3'd2,
    StAcquire = 3'd3,
    StTrack   = 3'd4,
    StFail    = 3'd5
  } link_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/strobe_run_counter.sv
// Counts consecutive qualified strobes; an unqualified strobe restarts the run.
module strobe_run_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic strobe_i,
  input  logic qual_i,
  output logic hit_o
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] Last = W'(LIMIT - 1);
  localparam logic [W-1:0] Max  = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (strobe_i) begin
      if (qual_i) cnt_d = (cnt_q == Max) ? cnt_q : cnt_q + W'(1);
      else        cnt_d = '0;
    end
  end

  // Fires only on the strobe that brings the run up to LIMIT.
  assign hit_o = !clear_i && strobe_i && qual_i && (cnt_q == Last);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/modem_link_ctrl.sv
// Link supervisor: flush, warm-up, lock acquisition with timeout, tracking and retry.
module modem_link_ctrl
  import modem_link_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES      = 16,
  parameter int unsigned WARMUP_SYMS       = 32,
  parameter int unsigned LOCK_TIMEOUT_SYMS = LINK_LOCK_TIMEOUT,
  parameter int unsigned LOCK_HOLD_SYMS    = LINK_LOCK_HOLD,
  parameter int unsigned UNLOCK_HOLD_SYMS  = LINK_UNLOCK_HOLD,
  parameter int unsigned MAX_RETRIES       = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NOISE_MAG_WIDTH-1:0] noise_mag_cfg,
  input  logic                       sym_tick,
  input  logic                       demod_valid,
  input  logic                       demod_lock,
  output logic                       tx_en,
  output logic                       rx_flush,
  output logic [NOISE_MAG_WIDTH-1:0] noise_magnitude,
  output logic                       link_up,
  output logic                       link_fail,
  output logic [2:0]                 state_o,
  output logic [1:0]                 retry_cnt,
  output logic [15:0]                lock_time
);

  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned WW = $clog2(WARMUP_SYMS + 1);
  localparam logic [FW-1:0] FlushLast  = FW'(FLUSH_CYCLES - 1);
  localparam logic [WW-1:0] WarmLast   = WW'(WARMUP_SYMS - 1);
  localparam logic [15:0]   AcqTimeout = 16'(LOCK_TIMEOUT_SYMS);
  localparam logic [1:0]    MaxRetry   = 2'(MAX_RETRIES);

  link_state_t state_q, state_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [WW-1:0] warm_cnt_q, warm_cnt_d;
  logic [15:0]   acq_cnt_q, acq_cnt_d, acq_inc;
  logic [1:0]    retry_q, retry_d;
  logic [NOISE_MAG_WIDTH-1:0] noise_q, noise_d;
  logic [15:0]   lock_time_q, lock_time_d;
  logic          link_fail_q, link_fail_d;
  logic          tx_en_q, tx_en_d, rx_flush_q, rx_flush_d, link_up_q, link_up_d;
  logic          hold_hit, loss_hit, fail_evt;

  assign acq_inc = sat_inc16(acq_cnt_q);

  strobe_run_counter #(.LIMIT(LOCK_HOLD_SYMS)) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q != StAcquire),
    .strobe_i (demod_valid),
    .qual_i   (demod_lock),
    .hit_o    (hold_hit)
  );

  strobe_run_counter #(.LIMIT(UNLOCK_HOLD_SYMS)) u_loss_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q != StTrack),
    .strobe_i (demod_valid),
    .qual_i   (!demod_lock),
    .hit_o    (loss_hit)
  );

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    noise_d     = noise_q;
    lock_time_d = lock_time_q;
    link_fail_d = link_fail_q;
    fail_evt    = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            noise_d     = noise_mag_cfg;
            retry_d     = '0;
            link_fail_d = 1'b0;
            state_d     = StFlush;
          end
        end
        StFlush:  if (flush_cnt_q == FlushLast) state_d = StWarmup;
        StWarmup: if (sym_tick && warm_cnt_q == WarmLast) state_d = StAcquire;
        StAcquire: begin
          // Lock takes priority when it lands on the timeout symbol.
          if (demod_valid) begin
            if (hold_hit) begin
              lock_time_d = acq_inc;
              state_d     = StTrack;
            end else if (acq_inc == AcqTimeout) begin
              fail_evt = 1'b1;
            end
          end
        end
        StTrack: if (loss_hit) fail_evt = 1'b1;
        StFail: begin
          if (start) begin
            retry_d = '0;
            state_d = StFlush;
          end
        end
        default: state_d = StIdle;
      endcase
      if (fail_evt) begin
        if (retry_q < MaxRetry) begin
          retry_d = retry_q + 2'd1;
          state_d = StFlush;
        end else begin
          link_fail_d = 1'b1;
          state_d     = StFail;
        end
      end
    end
  end

  // Per-state counters restart whenever their state is (re)entered.
  always_comb begin
    flush_cnt_d = '0;
    warm_cnt_d  = '0;
    acq_cnt_d   = '0;
    if (state_q == StFlush && state_d == StFlush) flush_cnt_d = flush_cnt_q + FW'(1);
    if (state_q == StWarmup && state_d == StWarmup) warm_cnt_d = warm_cnt_q + WW'(sym_tick);
    if (state_q == StAcquire && state_d == StAcquire) acq_cnt_d = demod_valid ? acq_inc : acq_cnt_q;
    tx_en_d    = (state_d == StWarmup) || (state_d == StAcquire) || (state_d == StTrack);
    rx_flush_d = (state_d == StFlush);
    link_up_d  = (state_d == StTrack);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      flush_cnt_q <= '0;
      warm_cnt_q  <= '0;
      acq_cnt_q   <= '0;
      retry_q     <= '0;
      noise_q     <= '0;
      lock_time_q <= '0;
      link_fail_q <= 1'b0;
      tx_en_q     <= 1'b0;
      rx_flush_q  <= 1'b0;
      link_up_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
      acq_cnt_q   <= acq_cnt_d;
      retry_q     <= retry_d;
      noise_q     <= noise_d;
      lock_time_q <= lock_time_d;
      link_fail_q <= link_fail_d;
      tx_en_q     <= tx_en_d;
      rx_flush_q  <= rx_flush_d;
      link_up_q   <= link_up_d;
    end
  end

  assign state_o         = state_q;
  assign tx_en           = tx_en_q;
  assign rx_flush        = rx_flush_q;
  assign noise_magnitude = noise_q;
  assign link_up         = link_up_q;
  assign link_fail       = link_fail_q;
  assign retry_cnt       = retry_q;
  assign lock_time       = lock_time_q;

endmodule

// File: tb/tb_modem_link_ctrl.sv
// Scoreboard bench: a behavioural model predicts every state change; a monitor checks them.
module tb_modem_link_ctrl;

  localparam int S_IDLE = 0, S_FLUSH = 1, S_WARMUP = 2, S_ACQ = 3, S_TRACK = 4, S_FAIL = 5;
  localparam int M_LOCK200 = 0, M_NEVER = 1, M_COINCIDE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic        sym_tick = 1'b0, demod_valid = 1'b0, demod_lock = 1'b0;
  logic [7:0]  noise_mag_cfg = 8'd0;
  logic        tx_en, rx_flush, link_up, link_fail;
  logic [7:0]  noise_magnitude;
  logic [2:0]  state_o;
  logic [1:0]  retry_cnt;
  logic [15:0] lock_time;

  always #5 clk = ~clk;

  modem_link_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .noise_mag_cfg   (noise_mag_cfg),
    .sym_tick        (sym_tick),
    .demod_valid     (demod_valid),
    .demod_lock      (demod_lock),
    .tx_en           (tx_en),
    .rx_flush        (rx_flush),
    .noise_magnitude (noise_magnitude),
    .link_up         (link_up),
    .link_fail       (link_fail),
    .state_o         (state_o),
    .retry_cnt       (retry_cnt),
    .lock_time       (lock_time)
  );

  typedef struct {
    longint t;
    int st, retry, noise, lt;
    bit tx, fl, up, fail;
  } exp_t;

  exp_t q[$];
  int n_vec = 0, n_err = 0;
  bit mon_en = 1'b0;

  // Reference model state
  int m_state = S_IDLE, m_retry = 0, m_fail = 0, m_noise = 0, m_lt = 0;
  int m_flush = 0, m_ticks = 0, m_acq = 0, m_run = 0, m_loss = 0;
  int mode = M_LOCK200, drop_left = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_step(bit st, bit ab, int cfg, bit tk, bit dv, bit lk, bit rs);
    int old;
    bit failure;
    exp_t e;
    old = m_state;
    failure = 1'b0;
    if (rs) begin
      m_state = S_IDLE; m_retry = 0; m_fail = 0; m_noise = 0; m_lt = 0;
    end else if (ab) begin
      m_state = S_IDLE;
    end else begin
      case (m_state)
        S_IDLE: if (st) begin
          m_noise = cfg; m_retry = 0; m_fail = 0; m_state = S_FLUSH; m_flush = 0;
        end
        S_FLUSH: begin
          m_flush++;
          if (m_flush == 16) begin m_state = S_WARMUP; m_ticks = 0; end
        end
        S_WARMUP: if (tk) begin
          m_ticks++;
          if (m_ticks == 32) begin m_state = S_ACQ; m_acq = 0; m_run = 0; end
        end
        S_ACQ: if (dv) begin
          m_acq++;
          m_run = lk ? m_run + 1 : 0;
          if (m_run == 16) begin
            m_lt = (m_acq > 65535) ? 65535 : m_acq;
            m_state = S_TRACK; m_loss = 0;
          end else if (m_acq == 800) failure = 1'b1;
        end
        S_TRACK: if (dv) begin
          m_loss = lk ? 0 : m_loss + 1;
          if (m_loss == 32) failure = 1'b1;
        end
        S_FAIL: if (st) begin m_retry = 0; m_state = S_FLUSH; m_flush = 0; end
        default: ;
      endcase
      if (failure) begin
        if (m_retry < 3) begin m_retry++; m_state = S_FLUSH; m_flush = 0; end
        else begin m_state = S_FAIL; m_fail = 1; end
      end
    end
    if (m_state != old) begin
      e.t = longint'($time) + 14;
      e.st = m_state; e.retry = m_retry; e.noise = m_noise; e.lt = m_lt;
      e.tx = (m_state == S_WARMUP) || (m_state == S_ACQ) || (m_state == S_TRACK);
      e.fl = (m_state == S_FLUSH);
      e.up = (m_state == S_TRACK);
      e.fail = (m_fail != 0);
      q.push_back(e);
    end
  endfunction

  function automatic bit pick_lock(bit dv);
    if (dv && m_state == S_ACQ) begin
      case (mode)
        M_LOCK200:  return m_acq >= 200;
        M_COINCIDE: return m_acq >= 784;
        default:    return 1'b0;
      endcase
    end
    if (dv && m_state == S_TRACK) begin
      if (drop_left > 0) begin drop_left--; return 1'b0; end
      return 1'b1;
    end
    return 1'($urandom_range(1));
  endfunction

  // Drives one cycle of stimulus, then returns at posedge+1 once it has been consumed.
  task automatic cycle(input bit st, input bit ab, input int cfg, input bit rs);
    bit tk, dv, lk;
    tk = ($urandom_range(3) != 0);
    dv = ($urandom_range(3) != 0);
    lk = pick_lock(dv);
    if (!st && !rs && m_state >= S_FLUSH && m_state <= S_TRACK && $urandom_range(63) == 0)
      st = 1'b1;
    start = st; abort = ab; rst = rs; noise_mag_cfg = 8'(cfg);
    sym_tick = tk; demod_valid = dv; demod_lock = lk;
    model_step(st, ab, cfg & 255, tk, dv, lk, rs);
    @(posedge clk); #1;
  endtask

  task automatic run_until(input int target, input int guard, input string name);
    int g;
    g = 0;
    while (m_state != target && g < guard) begin
      cycle(0, 0, int'($urandom_range(255)), 0);
      g++;
    end
    if (m_state != target) begin
      n_vec++; n_err++;
      $display("FAIL %s: timeout, model state %0d, wanted %0d", name, m_state, target);
    end
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, int'($urandom_range(255)), 0);
  endtask

  // Monitor: every DUT state change must match the next predicted snapshot.
  initial begin : monitor
    exp_t e;
    logic [2:0] prev;
    wait (mon_en);
    prev = 3'd0;
    forever begin
      @(negedge clk);
      if (state_o !== prev) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_transition: state_o %0d from %0d with nothing predicted",
                   state_o, prev);
        end else begin
          e = q.pop_front();
          chk("trans_time", longint'($time), e.t);
          chk("state_o", longint'(state_o), e.st);
          chk("retry_cnt", longint'(retry_cnt), e.retry);
          chk("tx_en", longint'(tx_en), e.tx);
          chk("rx_flush", longint'(rx_flush), e.fl);
          chk("link_up", longint'(link_up), e.up);
          chk("link_fail", longint'(link_fail), e.fail);
          chk("noise_magnitude", longint'(noise_magnitude), e.noise);
          chk("lock_time", longint'(lock_time), e.lt);
        end
        prev = state_o;
      end
    end
  end

  initial begin : driver
    int g;
    @(posedge clk); #1;
    repeat (3) cycle(0, 0, 0, 1);
    chk("rst_state", state_o, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_rx_flush", rx_flush, 0);
    chk("rst_noise", noise_magnitude, 0);
    chk("rst_link_up", link_up, 0);
    chk("rst_link_fail", link_fail, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_lock_time", lock_time, 0);
    mon_en = 1'b1;
    quiet(3);

    // Bring-up with lock from RX symbol 200
    mode = M_LOCK200;
    cycle(1, 0, 24, 0);
    run_until(S_TRACK, 6000, "bringup");
    chk("t1_lock_time", lock_time, 216);
    chk("t1_noise", noise_magnitude, 24);
    chk("t1_link_up", link_up, 1);
    quiet(30);

    // 31-symbol drop is tolerated, 32 triggers a retry
    drop_left = 31;
    g = 0;
    while (drop_left > 0 && g < 2000) begin quiet(1); g++; end
    quiet(40);
    chk("t3_glitch_link_up", link_up, 1);
    chk("t3_glitch_retry", retry_cnt, 0);
    drop_left = 32;
    run_until(S_FLUSH, 2000, "loss");
    chk("t3_loss_retry", retry_cnt, 1);
    chk("t3_loss_state", state_o, S_FLUSH);
    cycle(0, 1, 7, 0);
    quiet(4);

    // Four timeouts exhaust the retries
    mode = M_NEVER;
    cycle(1, 0, 90, 0);
    run_until(S_FAIL, 20000, "timeouts");
    chk("t2_link_fail", link_fail, 1);
    chk("t2_tx_en", tx_en, 0);
    chk("t2_retry", retry_cnt, 3);
    quiet(20);

    // Lock and timeout on the same symbol: lock wins
    mode = M_COINCIDE;
    cycle(1, 0, 5, 0);
    run_until(S_TRACK, 6000, "coincide");
    chk("t4_lock_time", lock_time, 800);
    chk("t4_retry", retry_cnt, 0);
    quiet(10);

    // Abort in ACQUIRE beats a simultaneous start
    cycle(0, 1, 0, 0);
    mode = M_LOCK200;
    cycle(1, 0, 33, 0);
    run_until(S_ACQ, 2000, "to_acquire");
    g = 0;
    while (m_acq < 10 && g < 200) begin quiet(1); g++; end
    cycle(1, 1, 99, 0);
    chk("t5_state", state_o, S_IDLE);
    chk("t5_tx_en", tx_en, 0);
    chk("t5_noise", noise_magnitude, 33);
    quiet(5);
    cycle(1, 0, 60, 0);
    run_until(S_TRACK, 6000, "restart");
    chk("t5_noise60", noise_magnitude, 60);
    quiet(10);

    // Reset while tracking
    cycle(0, 0, 0, 1);
    chk("t6_state", state_o, 0);
    chk("t6_link_up", link_up, 0);
    chk("t6_tx_en", tx_en, 0);
    chk("t6_lock_time", lock_time, 0);
    chk("t6_noise", noise_magnitude, 0);
    chk("t6_link_fail", link_fail, 0);
    quiet(5);

    @(negedge clk);
    @(negedge clk);
    chk("pending_predictions", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
